// File: rtl/vend_pkg.sv
// Shared encodings for the vending dispense scheduler: product codes, FSM states, stock limits.
package vend_pkg;

  localparam logic [1:0] PROD_A = 2'd0;
  localparam logic [1:0] PROD_B = 2'd1;
  localparam logic [1:0] PROD_C = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_JAM   = 2'd3
  } state_e;

  function automatic int unsigned stock_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned STOCK_W_DEF = 4;
  localparam int unsigned STOCK_MAX   = stock_max(STOCK_W_DEF);

endpackage

// File: rtl/vend_dispense_sched_if.sv
// Grant/refill/motor handshake bundle between the vending front end and the dispense scheduler.
interface vend_dispense_sched_if;
  logic       req_a;
  logic       req_b;
  logic       req_c;
  logic       refill;
  logic [1:0] refill_sel;
  logic       motor_done;
  logic       motor_start;
  logic [1:0] motor_sel;
  logic [2:0] sold_out;
  logic       refund;
  logic       jam;
  logic       busy;

  modport slave (
    input  req_a, req_b, req_c, refill, refill_sel, motor_done,
    output motor_start, motor_sel, sold_out, refund, jam, busy
  );

  modport master (
    output req_a, req_b, req_c, refill, refill_sel, motor_done,
    input  motor_start, motor_sel, sold_out, refund, jam, busy
  );
endinterface

// File: rtl/vend_req_fifo.sv
// Small synchronous FIFO of product codes; full is judged before any same-cycle pop.
module vend_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         empty_next_c
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    full         = (cnt_q == (AW+1)'(DEPTH));
    empty        = (cnt_q == '0);
    do_push      = push && !full;
    do_pop       = pop && !empty;
    wr_d         = do_push ? wr_q + AW'(1) : wr_q;
    rd_d         = do_pop  ? rd_q + AW'(1) : rd_q;
    cnt_d        = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    empty_next_c = (cnt_d == '0);
    dout         = mem_q[rd_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/vend_dispense_sched.sv
// Dispense scheduler: reserves stock per grant, queues grants, drives the shared motor,
// and refunds every paid grant that cannot be served (rejects, multi-grants, jams).
module vend_dispense_sched
  import vend_pkg::*;
#(
  parameter int unsigned STOCK_W    = STOCK_W_DEF,
  parameter int unsigned STOCK_INIT = 8,
  parameter int unsigned Q_DEPTH    = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  vend_dispense_sched_if.slave bus
);
  localparam int unsigned        TIMER_W = $clog2(TIMEOUT) + 1;
  localparam logic [STOCK_W-1:0] STK_MAX = STOCK_W'(stock_max(STOCK_W));

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [STOCK_W-1:0]   stock_q [3];
  logic [STOCK_W-1:0]   stock_d [3];
  logic                 pend_q, pend_d;
  logic [1:0]           motor_sel_q, motor_sel_d;
  logic                 motor_start_q, refund_q, refund_d, jam_q, busy_q, busy_d;
  logic [2:0]           sold_out_q, sold_out_d;

  logic       any_req, multi_req, sel_zero, accept, req_refund;
  logic       pop, flush, tout;
  logic [1:0] req_sel, fifo_dout;
  logic       fifo_full, fifo_empty, fifo_empty_next_c;

  // Grant decode: A beats B beats C; extra grants in the same cycle are refunded once.
  always_comb begin
    any_req   = bus.req_a | bus.req_b | bus.req_c;
    multi_req = (bus.req_a & bus.req_b) | (bus.req_a & bus.req_c) | (bus.req_b & bus.req_c);
    req_sel   = bus.req_a ? PROD_A : (bus.req_b ? PROD_B : PROD_C);
    sel_zero  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (req_sel == 2'(i)) sel_zero = (stock_q[i] == '0);
    end
    accept     = any_req && (state_q != S_JAM) && !sel_zero && !fifo_full;
    req_refund = any_req && (!accept || multi_req);
  end

  vend_req_fifo #(.DEPTH(Q_DEPTH), .W(2)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (accept),
    .pop          (pop),
    .din          (req_sel),
    .dout         (fifo_dout),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .empty_next_c (fifo_empty_next_c)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pend_d      = pend_q;
    motor_sel_d = motor_sel_q;
    stock_d     = stock_q;
    pop         = 1'b0;
    flush       = 1'b0;
    tout        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          motor_sel_d = fifo_dout;
          state_d     = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.motor_done) begin
          state_d = S_IDLE;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          state_d = S_JAM;
          tout    = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_JAM: begin
        // A new grant steals the refund slot; a deferred jam refund goes before the flush.
        if (!any_req) begin
          if (pend_q) begin
            pend_d = 1'b0;
          end else if (!fifo_empty) begin
            pop   = 1'b1;
            flush = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout colliding with a rejected grant: refund the grant now, the jam item later.
    if (req_refund && tout) pend_d = 1'b1;
    refund_d = req_refund | tout | ((state_q == S_JAM) && !any_req && (pend_q || !fifo_empty));

    // Refill lands first, then the reservation or the flush restore.
    for (int i = 0; i < 3; i++) begin
      if (bus.refill && (bus.refill_sel == 2'(i))) stock_d[i] = STK_MAX;
      if (accept && (req_sel == 2'(i)))            stock_d[i] = stock_d[i] - STOCK_W'(1);
      if (flush && (fifo_dout == 2'(i)) && (stock_d[i] != STK_MAX))
        stock_d[i] = stock_d[i] + STOCK_W'(1);
      sold_out_d[i] = (stock_d[i] == '0);
    end

    busy_d = (state_d != S_IDLE) || !fifo_empty_next_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      pend_q        <= 1'b0;
      motor_sel_q   <= PROD_A;
      motor_start_q <= 1'b0;
      refund_q      <= 1'b0;
      jam_q         <= 1'b0;
      busy_q        <= 1'b0;
      sold_out_q    <= '0;
      for (int i = 0; i < 3; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pend_q        <= pend_d;
      motor_sel_q   <= motor_sel_d;
      motor_start_q <= (state_d == S_START);
      refund_q      <= refund_d;
      jam_q         <= (state_d == S_JAM);
      busy_q        <= busy_d;
      sold_out_q    <= sold_out_d;
      for (int i = 0; i < 3; i++) stock_q[i] <= stock_d[i];
    end
  end

  assign bus.motor_start = motor_start_q;
  assign bus.motor_sel   = motor_sel_q;
  assign bus.sold_out    = sold_out_q;
  assign bus.refund      = refund_q;
  assign bus.jam         = jam_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_vend_dispense_sched.sv
// Bench for vend_dispense_sched: directed scenarios plus random traffic against a queue-based model.
module tb_vend_dispense_sched;
  localparam int TIMEOUT = 16;
  localparam int QD      = 4;
  localparam int SMAX    = 15;
  localparam int SINIT   = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vend_dispense_sched_if bus();

  vend_dispense_sched #(
    .STOCK_W(4), .STOCK_INIT(SINIT), .Q_DEPTH(QD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rcount   = 0;

  // Reference model: queue of reserved grants plus motor activity flags.
  int         m_stock [3];
  int         m_q [$];
  bit         m_start, m_wait, m_jam, m_pend;
  int         m_cnt;
  bit         e_start, e_refund, e_jam, e_busy;
  logic [1:0] e_sel = 2'd0;
  logic [2:0] e_sold = 3'd0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit any, multi, full;
    int top, r, flush_p;
    r = 0;
    if (reset) begin
      m_q.delete();
      for (int i = 0; i < 3; i++) m_stock[i] = SINIT;
      m_start = 0; m_wait = 0; m_jam = 0; m_pend = 0; m_cnt = 0;
      e_sel = 2'd0;
    end else begin
      any     = bus.req_a | bus.req_b | bus.req_c;
      multi   = (int'(bus.req_a) + int'(bus.req_b) + int'(bus.req_c)) > 1;
      top     = bus.req_a ? 0 : (bus.req_b ? 1 : 2);
      full    = m_q.size() >= QD;
      flush_p = -1;
      begin : grants
        bit acc;
        acc = 0;
        if (any) begin
          if (m_jam) r = 1;
          else begin
            if (m_stock[top] > 0 && !full) acc = 1; else r = 1;
            if (multi) r = 1;
          end
        end
        if (m_jam) begin
          if (!any && m_pend) begin m_pend = 0; r = 1; end
          else if (!any && m_q.size() > 0) begin flush_p = m_q.pop_front(); r = 1; end
        end else if (m_start) begin
          m_start = 0; m_wait = 1; m_cnt = 0;
        end else if (m_wait) begin
          if (bus.motor_done) m_wait = 0;
          else if (m_cnt == TIMEOUT - 1) begin
            m_wait = 0; m_jam = 1;
            if (r != 0) m_pend = 1; else r = 1;
          end else m_cnt++;
        end else if (m_q.size() > 0) begin
          e_sel   = 2'(m_q.pop_front());
          m_start = 1;
        end
        if (bus.refill && bus.refill_sel != 2'd3) m_stock[bus.refill_sel] = SMAX;
        if (acc) begin m_stock[top]--; m_q.push_back(top); end
        if (flush_p >= 0 && m_stock[flush_p] < SMAX) m_stock[flush_p]++;
      end
    end
    e_start  = m_start;
    e_refund = (r != 0);
    e_jam    = m_jam;
    e_busy   = m_start || m_wait || m_jam || (m_q.size() > 0);
    for (int i = 0; i < 3; i++) e_sold[i] = (m_stock[i] == 0);
  end

  always @(posedge clk) rcount <= rcount + int'(bus.refund);

  always @(negedge clk) begin
    chk("motor_start", int'(bus.motor_start), int'(e_start));
    chk("motor_sel",   int'(bus.motor_sel),   int'(e_sel));
    chk("sold_out",    int'(bus.sold_out),    int'(e_sold));
    chk("refund",      int'(bus.refund),      int'(e_refund));
    chk("jam",         int'(bus.jam),         int'(e_jam));
    chk("busy",        int'(bus.busy),        int'(e_busy));
  end

  task automatic pulse_req(input bit a, input bit b, input bit c);
    bus.req_a = a; bus.req_b = b; bus.req_c = c;
    @(negedge clk);
    bus.req_a = 0; bus.req_b = 0; bus.req_c = 0;
  endtask

  task automatic wait_start(input int max);
    int k = 0;
    while (!bus.motor_start && k < max) begin @(negedge clk); k++; end
    chk("wait_start_bound", int'(bus.motor_start), 1);
  endtask

  task automatic serve(input int sel, input string name);
    wait_start(8);
    chk(name, int'(bus.motor_sel), sel);
    @(negedge clk);
    bus.motor_done = 1;
    @(negedge clk);
    bus.motor_done = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  initial begin
    int r0, k;
    bus.req_a = 0; bus.req_b = 0; bus.req_c = 0;
    bus.refill = 0; bus.refill_sel = 2'd0; bus.motor_done = 0;
    repeat (3) @(negedge clk);
    chk("rst_motor_start", int'(bus.motor_start), 0);
    chk("rst_sold_out",    int'(bus.sold_out),    0);
    chk("rst_refund",      int'(bus.refund),      0);
    chk("rst_jam",         int'(bus.jam),         0);
    chk("rst_busy",        int'(bus.busy),        0);
    reset = 0;

    // Single A grant: start two cycles after the grant, then idle after done.
    pulse_req(1, 0, 0);
    chk("t1_no_start_n1", int'(bus.motor_start), 0);
    chk("t1_busy_n1",     int'(bus.busy),        1);
    @(negedge clk);
    chk("t1_start_n2",    int'(bus.motor_start), 1);
    chk("t1_sel_a",       int'(bus.motor_sel),   0);
    repeat (2) @(negedge clk);
    bus.motor_done = 1;
    @(negedge clk);
    bus.motor_done = 0;
    @(negedge clk);
    chk("t1_idle_busy",  int'(bus.busy), 0);
    chk("t1_model_stock_a", m_stock[0], 7);

    // Motor held on A while five B grants arrive: four queue, the fifth is refunded.
    pulse_req(1, 0, 0);
    wait_start(4);
    r0 = rcount;
    bus.req_b = 1;
    repeat (5) @(negedge clk);
    bus.req_b = 0;
    repeat (2) @(negedge clk);
    chk("t2_refunds", rcount - r0, 1);
    chk("t2_model_stock_b", m_stock[1], 4);
    bus.motor_done = 1;
    @(negedge clk);
    bus.motor_done = 0;
    repeat (4) serve(1, "t2_sel_b");

    // Drain C to sold out, reject the next grant, then refill.
    repeat (8) begin
      pulse_req(0, 0, 1);
      serve(2, "t3_sel_c");
    end
    @(negedge clk);
    chk("t3_sold_out_c", int'(bus.sold_out[2]), 1);
    pulse_req(0, 0, 1);
    chk("t3_refund", int'(bus.refund), 1);
    @(negedge clk);
    chk("t3_no_push_busy", int'(bus.busy), 0);
    bus.refill = 1; bus.refill_sel = 2'd2;
    @(negedge clk);
    bus.refill = 0;
    @(negedge clk);
    chk("t3_refilled", int'(bus.sold_out[2]), 0);
    chk("t3_model_stock_c", m_stock[2], 15);

    // Jam with two A grants queued behind the stuck one.
    do_reset();
    pulse_req(1, 0, 0);
    wait_start(4);
    bus.req_a = 1;
    repeat (2) @(negedge clk);
    bus.req_a = 0;
    r0 = rcount;
    k = 0;
    while (!bus.jam && k < 40) begin @(negedge clk); k++; end
    chk("t4_jam", int'(bus.jam), 1);
    repeat (8) @(negedge clk);
    chk("t4_refunds", rcount - r0, 3);
    chk("t4_model_stock_a", m_stock[0], 7);
    chk("t4_jam_sticky", int'(bus.jam), 1);

    // Simultaneous A and C grants.
    do_reset();
    pulse_req(1, 0, 1);
    chk("t5_refund", int'(bus.refund), 1);
    chk("t5_model_stock_c", m_stock[2], 8);
    chk("t5_model_stock_a", m_stock[0], 7);
    serve(0, "t5_sel_a");

    // Reset in the middle of a wait with two grants queued.
    do_reset();
    pulse_req(1, 0, 0);
    wait_start(4);
    bus.req_a = 1;
    repeat (2) @(negedge clk);
    bus.req_a = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("t6_start",    int'(bus.motor_start), 0);
    chk("t6_refund",   int'(bus.refund),      0);
    chk("t6_busy",     int'(bus.busy),        0);
    chk("t6_jam",      int'(bus.jam),         0);
    chk("t6_sold_out", int'(bus.sold_out),    0);
    reset = 0;
    r0 = rcount;
    repeat (20) @(negedge clk);
    chk("t6_no_refund", rcount - r0, 0);
    chk("t6_model_stock_a", m_stock[0], 8);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int p;
      p = int'($urandom_range(0, 99));
      bus.req_a = 0; bus.req_b = 0; bus.req_c = 0;
      if (p < 5) begin
        bus.req_a = 1'($urandom_range(0, 1));
        bus.req_b = 1'($urandom_range(0, 1));
        bus.req_c = 1;
      end else if (p < 35) begin
        case ($urandom_range(0, 2))
          0:       bus.req_a = 1;
          1:       bus.req_b = 1;
          default: bus.req_c = 1;
        endcase
      end
      bus.refill     = ($urandom_range(0, 99) < 3);
      bus.refill_sel = 2'($urandom_range(0, 3));
      bus.motor_done = ($urandom_range(0, 99) < 12);
      reset          = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    bus.req_a = 0; bus.req_b = 0; bus.req_c = 0;
    bus.refill = 0; bus.motor_done = 0; reset = 0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
